serial_adder: RTL

Bit-serial ripple adder that accepts two WIDTH-bit operands plus carry-in through a valid/ready handshake. It streams them LSB-first through a single one-bit full-adder cell, keeping the carry in a flop between bits. It presents {c_out, sum} through a second valid/ready handshake. The block sits directly upstream of the one-bit full-adder cell: it sequences operands into it, collects what it produces, and trades latency for area in the arithmetic path.

---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/serial_adder_fa_bit.sv | 14 +
 rtl/serial_adder.sv | 96 +++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// Holds the FSM state encoding and the counter-width function.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter must hold WIDTH-1; keep at least one bit for WIDTH=1.
    function automatic int cnt_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_adder_fa_bit.sv
// One-bit full adder cell used by serial_adder.
// Ports: a, b, ci -> s (sum bit), co (carry out). Purely combinational.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: streams a, b, c_in LSB-first through one fa_bit.
// Ports: clk, rst_n (sync, active-low), in_valid/in_ready + a, b, c_in
// operand handshake; out_valid/out_ready + sum, c_out result handshake.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             s;
    logic             co;
    logic [WIDTH:0]   sum_ins;

    fa_bit u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (s),
        .co (co)
    );

    // New bit enters at the MSB; dropping bit 0 gives the shifted value.
    // Written this way so WIDTH=1 needs no special case.
    assign sum_ins = {s, sum_sh};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= c_in;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sum_sh <= sum_ins[WIDTH:1];
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= co;
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_sh;
    assign c_out     = carry;

endmodule
